axi_lite_protocol_checker: RTL and testbench
============================================

// Module: axi_lite_protocol_checker
// PURPOSE
// Synthesizable AXI4-Lite protocol checker: parametrised successor of the bench-only axi_intf SVA checks.
// Passively monitors all five AXI-Lite channels between AXI master and axi2apb bridge.
// Flags handshake/stability/ordering/timeout violations; errors are sticky, counted and latched (first error).
// Feeds irq to system; usable in FPGA builds, where simulation-only assertions do not exist.
// PARAMETERS
// ADDR_W          32    AWADDR/ARADDR width
// DATA_W          32    WDATA/RDATA width
// MAX_OUTSTANDING 4     max accepted-but-unanswered txns per direction; exceeding -> OVF error
// TIMEOUT_CYCLES  1024  max cycles VALID may wait for READY on any channel (>=2)
// CNT_W           16    err_count width (saturating)
// PORTS
// aclk            in   1       clock, all logic on posedge
// areset          in   1       synchronous, active-high reset
// axi_awaddr/awvalid/awready                    in  ADDR_W/1/1    AW channel
// axi_wdata/wvalid/wready                       in  DATA_W/1/1    W channel
// axi_bresp/bvalid/bready                       in  2/1/1         B channel
// axi_araddr/arvalid/arready                    in  ADDR_W/1/1    AR channel
// axi_rdata/rresp/rvalid/rready                 in  DATA_W/2/1/1  R channel
// err_mask        in   11      1=check enabled toward irq (sticky/count always record)
// clr             in   1       clear sticky, count, first-error capture
// err_pulse       out  11      one-cycle per-check error strobe
// err_sticky      out  11      per-check sticky flags
// err_count       out  CNT_W   total errors (popcount of err_pulse per cycle), saturates at all-ones
// first_err_id    out  4       index of lowest-set bit of first non-zero err_pulse after reset/clr
// first_err_valid out  1       first_err_id holds a capture
// irq             out  1       |(err_sticky & err_mask), registered
// BEHAVIOUR
// - Reset: every output 0; prev-sample regs, outstanding and wait counters 0.
// - Sample at posedge t; err_pulse asserts in cycle t+1 (1-cycle latency); sticky/count/first/irq update with it.
// - Check indices: 0 AW_VALID_DROP, 1 AW_ADDR_UNSTABLE, 2 W_VALID_DROP, 3 W_DATA_UNSTABLE,
//   4 AR_VALID_DROP, 5 AR_ADDR_UNSTABLE, 6 B_UNEXPECTED, 7 R_UNEXPECTED, 8 RESP_UNSTABLE,
//   9 TIMEOUT, 10 OUTSTANDING_OVF.
// - VALID_DROP: prev valid=1, prev ready=0, now valid=0. UNSTABLE: prev valid=1, prev ready=0, payload changed.
// - RESP_UNSTABLE: same rule on bresp or {rresp,rdata}; B/R VALID drop also maps to bit 8.
// - Outstanding: wr_a (AW hs minus B hs), wr_d (W hs minus B hs), rd (AR hs minus R hs); width $clog2(MAX_OUTSTANDING+2).
// - B hs with wr_a==0 or wr_d==0 counting same-cycle AW/W hs as available -> B_UNEXPECTED, counters not decremented below 0.
// - R hs with rd==0 and no same-cycle AR hs -> R_UNEXPECTED.
// - Counter reaching MAX_OUTSTANDING+1 -> OVF once per crossing; counter saturates there.
// - Per-channel wait counter: ++ while valid&&!ready, 0 otherwise; ==TIMEOUT_CYCLES -> TIMEOUT once, holds until hs/drop.
// - First cycle after areset falls: stability/drop checks suppressed (no valid prev sample).
// - clr and new error same cycle: clear applied first, then new error recorded (sticky=pulse, count=popcount, capture).
// - Multiple checks same cycle: all pulse; first_err_id = lowest index.
// - areset mid-transaction: counters zeroed; B/R for pre-reset txns after reset are reported UNEXPECTED.
// STRUCTURE
// - Package axi_chk_pkg: chk_id_e enum (11 values above), NUM_CHECKS=11, CHK_ID_W=4, axi_resp_t.
// - Sub-module axi_chk_chan #(PAYLOAD_W, TIMEOUT_CYCLES): valid/ready/payload -> drop, unstable, timeout.
//   Instantiated 5x (AW, W, AR, B, R); top holds outstanding counters, OR-reduction of timeouts, error accounting.
// TESTING
// - Legal traffic: 100 random AW/W/B, AR/R with random stalls -> err_sticky==0, err_count==0, irq=0.
// - awvalid=1 awaddr=0x1000 awready=0, next cycle awaddr=0x1004 -> err_pulse[1] in t+1, first_err_id=1, err_count=1.
// - bvalid=bready=1 with no prior AW/W -> err_pulse[6]; same cycle as AW+W hs -> no error.
// - arvalid=1 held 1024 cycles with arready=0 -> single err_pulse[9] at cycle 1025; err_count=1.
// - 5 AR hs, no R, MAX_OUTSTANDING=4 -> err_pulse[10] once; err_mask[10]=1 -> irq=1; clr -> all 0 next cycle.
// - Error on cycle of clr -> err_sticky shows only new bit, err_count=1; areset mid-AW -> all outputs 0 next cycle.

Source files
------------

// File: rtl/axi_lite_protocol_checker_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : axi_chk_pkg                                                  |
// | Check identifiers and helpers shared by the AXI-Lite protocol checker. |
// | Rev     : 1.0                                                          |
// +-----------------------------------------------------------------------+
package axi_chk_pkg;

  localparam int NUM_CHECKS = 11;
  localparam int CHK_ID_W   = 4;

  typedef enum logic [CHK_ID_W-1:0] {
    CHK_AW_VALID_DROP    = 4'd0,
    CHK_AW_ADDR_UNSTABLE = 4'd1,
    CHK_W_VALID_DROP     = 4'd2,
    CHK_W_DATA_UNSTABLE  = 4'd3,
    CHK_AR_VALID_DROP    = 4'd4,
    CHK_AR_ADDR_UNSTABLE = 4'd5,
    CHK_B_UNEXPECTED     = 4'd6,
    CHK_R_UNEXPECTED     = 4'd7,
    CHK_RESP_UNSTABLE    = 4'd8,
    CHK_TIMEOUT          = 4'd9,
    CHK_OUTSTANDING_OVF  = 4'd10
  } chk_id_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  function automatic logic [CHK_ID_W-1:0] f_popcount(input logic [NUM_CHECKS-1:0] v);
    logic [CHK_ID_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CHECKS; i++) n = n + CHK_ID_W'(v[i]);
    return n;
  endfunction

  function automatic logic [CHK_ID_W-1:0] f_lowest(input logic [NUM_CHECKS-1:0] v);
    logic [CHK_ID_W-1:0] id;
    id = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) if (v[i]) id = CHK_ID_W'(i);
    return id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_protocol_checker_chan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : axi_chk_chan                                                  |
// | One VALID/READY channel monitor: valid drop, payload change, timeout.  |
// | Rev    : 1.0                                                           |
// +-----------------------------------------------------------------------+
module axi_chk_chan #(
  parameter int PAYLOAD_W      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_ready,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic                 o_drop,
  output logic                 o_unstable,
  output logic                 o_timeout
);

  localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tw-1:0] c_wait_lim  = c_tw'(TIMEOUT_CYCLES);
  localparam logic [c_tw-1:0] c_wait_last = c_tw'(TIMEOUT_CYCLES - 1);

  logic                 r_prev_valid;
  logic                 r_prev_ready;
  logic [PAYLOAD_W-1:0] r_prev_payload;
  logic [c_tw-1:0]      r_wait;
  logic                 w_held;
  logic                 w_stall;

  // Zeroed previous-sample registers make the first post-reset cycle check-free.
  assign w_held  = r_prev_valid & ~r_prev_ready;
  assign w_stall = i_valid & ~i_ready;

  // Payload compare only while VALID is still up; a drop is reported on its own.
  assign o_drop     = w_held & ~i_valid;
  assign o_unstable = w_held & i_valid & (i_payload != r_prev_payload);
  assign o_timeout  = w_stall & (r_wait == c_wait_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_valid   <= 1'b0;
      r_prev_ready   <= 1'b0;
      r_prev_payload <= '0;
      r_wait         <= '0;
    end else begin
      r_prev_valid   <= i_valid;
      r_prev_ready   <= i_ready;
      r_prev_payload <= i_payload;
      if (!w_stall)
        r_wait <= '0;
      else if (r_wait != c_wait_lim)
        r_wait <= r_wait + c_tw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_protocol_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : axi_lite_protocol_checker                                     |
// | Passive AXI4-Lite monitor with sticky, counted and captured errors.    |
// | Rev    : 1.0                                                           |
// +-----------------------------------------------------------------------+
module axi_lite_protocol_checker
  import axi_chk_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int CNT_W           = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_W-1:0]     axi_awaddr,
  input  logic                  axi_awvalid,
  input  logic                  axi_awready,
  input  logic [DATA_W-1:0]     axi_wdata,
  input  logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  input  logic                  axi_bready,
  input  logic [ADDR_W-1:0]     axi_araddr,
  input  logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_W-1:0]     axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  input  logic                  axi_rready,
  input  logic [NUM_CHECKS-1:0] err_mask,
  input  logic                  clr,
  output logic [NUM_CHECKS-1:0] err_pulse,
  output logic [NUM_CHECKS-1:0] err_sticky,
  output logic [CNT_W-1:0]      err_count,
  output logic [CHK_ID_W-1:0]   first_err_id,
  output logic                  first_err_valid,
  output logic                  irq
);

  localparam int c_ow  = $clog2(MAX_OUTSTANDING + 2);
  localparam int c_cw1 = CNT_W + 1;
  localparam logic [c_ow-1:0] c_osat = c_ow'(MAX_OUTSTANDING + 1);

  // Counter step that never goes below zero and saturates one past the limit.
  function automatic logic [c_ow-1:0] f_step(input logic [c_ow-1:0] cur,
                                             input logic inc, input logic dec);
    logic [c_ow:0] s;
    s = {1'b0, cur} + {{c_ow{1'b0}}, inc} - {{c_ow{1'b0}}, dec};
    return (s >= {1'b0, c_osat}) ? c_osat : s[c_ow-1:0];
  endfunction

  logic w_aw_drop, w_aw_unst, w_aw_to;
  logic w_w_drop,  w_w_unst,  w_w_to;
  logic w_ar_drop, w_ar_unst, w_ar_to;
  logic w_b_drop,  w_b_unst,  w_b_to;
  logic w_r_drop,  w_r_unst,  w_r_to;

  axi_chk_chan #(.PAYLOAD_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_aw (
    .clk(aclk), .rst(areset), .i_valid(axi_awvalid), .i_ready(axi_awready),
    .i_payload(axi_awaddr), .o_drop(w_aw_drop), .o_unstable(w_aw_unst), .o_timeout(w_aw_to));

  axi_chk_chan #(.PAYLOAD_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_w (
    .clk(aclk), .rst(areset), .i_valid(axi_wvalid), .i_ready(axi_wready),
    .i_payload(axi_wdata), .o_drop(w_w_drop), .o_unstable(w_w_unst), .o_timeout(w_w_to));

  axi_chk_chan #(.PAYLOAD_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ar (
    .clk(aclk), .rst(areset), .i_valid(axi_arvalid), .i_ready(axi_arready),
    .i_payload(axi_araddr), .o_drop(w_ar_drop), .o_unstable(w_ar_unst), .o_timeout(w_ar_to));

  axi_chk_chan #(.PAYLOAD_W(2), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_b (
    .clk(aclk), .rst(areset), .i_valid(axi_bvalid), .i_ready(axi_bready),
    .i_payload(axi_bresp), .o_drop(w_b_drop), .o_unstable(w_b_unst), .o_timeout(w_b_to));

  axi_chk_chan #(.PAYLOAD_W(DATA_W + 2), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_r (
    .clk(aclk), .rst(areset), .i_valid(axi_rvalid), .i_ready(axi_rready),
    .i_payload({axi_rresp, axi_rdata}), .o_drop(w_r_drop), .o_unstable(w_r_unst),
    .o_timeout(w_r_to));

  logic [c_ow-1:0] r_wr_a, r_wr_d, r_rd;
  logic [c_ow-1:0] w_wr_a_nxt, w_wr_d_nxt, w_rd_nxt;
  logic            w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic            w_wa_avail, w_wd_avail, w_rd_avail;
  logic            w_b_unexp, w_r_unexp, w_ovf;

  assign w_aw_hs = axi_awvalid & axi_awready;
  assign w_w_hs  = axi_wvalid  & axi_wready;
  assign w_ar_hs = axi_arvalid & axi_arready;
  assign w_b_hs  = axi_bvalid  & axi_bready;
  assign w_r_hs  = axi_rvalid  & axi_rready;

  // A request accepted in the same cycle as its response counts as available.
  assign w_wa_avail = (r_wr_a != '0) | w_aw_hs;
  assign w_wd_avail = (r_wr_d != '0) | w_w_hs;
  assign w_rd_avail = (r_rd   != '0) | w_ar_hs;

  assign w_b_unexp = w_b_hs & ~(w_wa_avail & w_wd_avail);
  assign w_r_unexp = w_r_hs & ~w_rd_avail;

  assign w_wr_a_nxt = f_step(r_wr_a, w_aw_hs, w_b_hs & w_wa_avail);
  assign w_wr_d_nxt = f_step(r_wr_d, w_w_hs,  w_b_hs & w_wd_avail);
  assign w_rd_nxt   = f_step(r_rd,   w_ar_hs, w_r_hs & w_rd_avail);

  assign w_ovf = ((w_wr_a_nxt == c_osat) & (r_wr_a != c_osat)) |
                 ((w_wr_d_nxt == c_osat) & (r_wr_d != c_osat)) |
                 ((w_rd_nxt   == c_osat) & (r_rd   != c_osat));

  logic [NUM_CHECKS-1:0] w_err;

  always_comb begin
    w_err = '0;
    w_err[CHK_AW_VALID_DROP]    = w_aw_drop;
    w_err[CHK_AW_ADDR_UNSTABLE] = w_aw_unst;
    w_err[CHK_W_VALID_DROP]     = w_w_drop;
    w_err[CHK_W_DATA_UNSTABLE]  = w_w_unst;
    w_err[CHK_AR_VALID_DROP]    = w_ar_drop;
    w_err[CHK_AR_ADDR_UNSTABLE] = w_ar_unst;
    w_err[CHK_B_UNEXPECTED]     = w_b_unexp;
    w_err[CHK_R_UNEXPECTED]     = w_r_unexp;
    w_err[CHK_RESP_UNSTABLE]    = w_b_drop | w_b_unst | w_r_drop | w_r_unst;
    w_err[CHK_TIMEOUT]          = w_aw_to | w_w_to | w_ar_to | w_b_to | w_r_to;
    w_err[CHK_OUTSTANDING_OVF]  = w_ovf;
  end

  logic [NUM_CHECKS-1:0] w_sticky_nxt;
  logic [CNT_W-1:0]      w_count_base, w_count_nxt;
  logic [CNT_W:0]        w_count_sum;
  logic [CHK_ID_W-1:0]   w_id_base, w_id_nxt;
  logic                  w_fv_base, w_fv_nxt;

  // clr wipes the accumulated state first, so a same-cycle error is kept.
  always_comb begin
    w_sticky_nxt = (clr ? '0 : err_sticky) | w_err;
    w_count_base = clr ? '0 : err_count;
    w_count_sum  = {1'b0, w_count_base} + c_cw1'(f_popcount(w_err));
    w_count_nxt  = w_count_sum[CNT_W] ? '1 : w_count_sum[CNT_W-1:0];
    w_fv_base    = clr ? 1'b0 : first_err_valid;
    w_id_base    = clr ? '0 : first_err_id;
    w_id_nxt     = (!w_fv_base && (|w_err)) ? f_lowest(w_err) : w_id_base;
    w_fv_nxt     = w_fv_base | (|w_err);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_a          <= '0;
      r_wr_d          <= '0;
      r_rd            <= '0;
      err_pulse       <= '0;
      err_sticky      <= '0;
      err_count       <= '0;
      first_err_id    <= '0;
      first_err_valid <= 1'b0;
      irq             <= 1'b0;
    end else begin
      r_wr_a          <= w_wr_a_nxt;
      r_wr_d          <= w_wr_d_nxt;
      r_rd            <= w_rd_nxt;
      err_pulse       <= w_err;
      err_sticky      <= w_sticky_nxt;
      err_count       <= w_count_nxt;
      first_err_id    <= w_id_nxt;
      first_err_valid <= w_fv_nxt;
      irq             <= |(w_sticky_nxt & err_mask);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_protocol_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_axi_lite_protocol_checker                                  |
// | Self-checking bench: directed scenarios plus random traffic vs model.  |
// | Rev    : 1.0                                                           |
// +-----------------------------------------------------------------------+
module tb_axi_lite_protocol_checker;

  localparam int MAXO = 4;
  localparam int TMO  = 1024;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] axi_awaddr = '0, axi_wdata = '0, axi_araddr = '0, axi_rdata = '0;
  logic        axi_awvalid = 0, axi_awready = 0, axi_wvalid = 0, axi_wready = 0;
  logic        axi_bvalid = 0, axi_bready = 0, axi_arvalid = 0, axi_arready = 0;
  logic        axi_rvalid = 0, axi_rready = 0;
  logic [1:0]  axi_bresp = '0, axi_rresp = '0;
  logic [10:0] err_mask = '0;
  logic        clr = 1'b0;

  logic [10:0] err_pulse, err_sticky;
  logic [15:0] err_count;
  logic [3:0]  first_err_id;
  logic        first_err_valid, irq;

  int vectors = 0;
  int miscompares = 0;

  axi_lite_protocol_checker dut (
    .aclk(aclk), .areset(areset),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .err_mask(err_mask), .clr(clr),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count),
    .first_err_id(first_err_id), .first_err_valid(first_err_valid), .irq(irq)
  );

  always #5 aclk = ~aclk;

  // Reference model: channels 0..4 = AW, W, AR, B, R
  logic        m_pv [5];
  logic        m_pr [5];
  logic [63:0] m_pp [5];
  int          m_sc [5];
  int          m_wa, m_wd, m_rd;
  logic [10:0] exp_pulse = '0, exp_sticky = '0;
  logic [15:0] exp_count = '0;
  logic [3:0]  exp_id = '0;
  logic        exp_fv = 1'b0, exp_irq = 1'b0;

  task automatic model_step();
    logic        cv [5];
    logic        cr [5];
    logic [63:0] cp [5];
    logic [10:0] e;
    logic        held, drop, unst;
    int aw, w, ar, b, r, wa_av, wd_av, rd_av, nwa, nwd, nrd, cnt;
    cv = '{axi_awvalid, axi_wvalid, axi_arvalid, axi_bvalid, axi_rvalid};
    cr = '{axi_awready, axi_wready, axi_arready, axi_bready, axi_rready};
    cp = '{64'(axi_awaddr), 64'(axi_wdata), 64'(axi_araddr), 64'(axi_bresp),
           64'({axi_rresp, axi_rdata})};
    if (areset) begin
      for (int c = 0; c < 5; c++) begin m_pv[c] = 0; m_pr[c] = 0; m_pp[c] = '0; m_sc[c] = 0; end
      m_wa = 0; m_wd = 0; m_rd = 0;
      exp_pulse = '0; exp_sticky = '0; exp_count = '0; exp_id = '0; exp_fv = 0; exp_irq = 0;
      return;
    end
    e = '0;
    for (int c = 0; c < 5; c++) begin
      held = m_pv[c] && !m_pr[c];
      drop = held && !cv[c];
      unst = held && cv[c] && (cp[c] != m_pp[c]);
      case (c)
        0: begin e[0] = e[0] | drop; e[1] = e[1] | unst; end
        1: begin e[2] = e[2] | drop; e[3] = e[3] | unst; end
        2: begin e[4] = e[4] | drop; e[5] = e[5] | unst; end
        default: e[8] = e[8] | drop | unst;
      endcase
      if (cv[c] && !cr[c]) begin
        m_sc[c]++;
        if (m_sc[c] == TMO) e[9] = 1'b1;
      end else m_sc[c] = 0;
      m_pv[c] = cv[c]; m_pr[c] = cr[c]; m_pp[c] = cp[c];
    end
    aw = int'(axi_awvalid && axi_awready); w = int'(axi_wvalid && axi_wready);
    ar = int'(axi_arvalid && axi_arready); b = int'(axi_bvalid && axi_bready);
    r  = int'(axi_rvalid && axi_rready);
    wa_av = m_wa + aw; wd_av = m_wd + w; rd_av = m_rd + ar;
    if (b == 1 && (wa_av == 0 || wd_av == 0)) e[6] = 1'b1;
    if (r == 1 && rd_av == 0) e[7] = 1'b1;
    nwa = wa_av - ((b == 1 && wa_av > 0) ? 1 : 0); if (nwa > MAXO + 1) nwa = MAXO + 1;
    nwd = wd_av - ((b == 1 && wd_av > 0) ? 1 : 0); if (nwd > MAXO + 1) nwd = MAXO + 1;
    nrd = rd_av - ((r == 1 && rd_av > 0) ? 1 : 0); if (nrd > MAXO + 1) nrd = MAXO + 1;
    if ((nwa == MAXO + 1 && m_wa != MAXO + 1) || (nwd == MAXO + 1 && m_wd != MAXO + 1) ||
        (nrd == MAXO + 1 && m_rd != MAXO + 1)) e[10] = 1'b1;
    m_wa = nwa; m_wd = nwd; m_rd = nrd;
    exp_pulse = e;
    if (clr) begin exp_sticky = '0; exp_count = '0; exp_fv = 0; exp_id = '0; end
    exp_sticky = exp_sticky | e;
    cnt = int'(exp_count) + $countones(e);
    exp_count = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
    if (!exp_fv && e != '0) begin
      exp_fv = 1'b1;
      for (int i = 10; i >= 0; i--) if (e[i]) exp_id = 4'(i);
    end
    exp_irq = |(exp_sticky & err_mask);
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    axi_awvalid = 0; axi_awready = 0; axi_wvalid = 0; axi_wready = 0;
    axi_bvalid = 0; axi_bready = 0; axi_arvalid = 0; axi_arready = 0;
    axi_rvalid = 0; axi_rready = 0; clr = 0;
  endtask

  task automatic reset_dut();
    set_idle();
    areset = 1'b1;
    tick(); tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    err_mask = '1;
    reset_dut();
    vectors++;
    if ({err_pulse, err_sticky, err_count, first_err_id, first_err_valid, irq} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got pulse=%h sticky=%h cnt=%0d id=%0d fv=%b irq=%b, want all 0",
               err_pulse, err_sticky, err_count, first_err_id, first_err_valid, irq);
    end
    tick();
    vectors++;
    if (err_pulse !== 11'd0 || err_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_idle: got pulse=%h cnt=%0d, want 0/0", err_pulse, err_count);
    end
  endtask

  task automatic test_legal_traffic();
    int is_wr, phase, guard;
    logic a_done, d_done;
    reset_dut();
    err_mask = '1;
    for (int n = 0; n < 100; n++) begin
      is_wr = int'($urandom_range(1, 0));
      phase = 0; guard = 0; a_done = 0; d_done = 0;
      if (is_wr == 1) begin
        axi_awaddr = $urandom; axi_wdata = $urandom; axi_awvalid = 1; axi_wvalid = 1;
      end else begin
        axi_araddr = $urandom; axi_arvalid = 1;
      end
      while (phase < 2 && guard < 100) begin
        axi_awready = 1'($urandom_range(1, 0)); axi_wready = 1'($urandom_range(1, 0));
        axi_arready = 1'($urandom_range(1, 0)); axi_bready = 1'($urandom_range(1, 0));
        axi_rready  = 1'($urandom_range(1, 0));
        tick();
        guard++;
        vectors++;
        if (err_pulse !== 11'd0 || exp_pulse !== 11'd0) begin
          miscompares++;
          $display("FAIL legal_pulse: got %h, want 000 (model %h)", err_pulse, exp_pulse);
        end
        if (is_wr == 1) begin
          if (phase == 0) begin
            if (axi_awvalid && axi_awready) begin a_done = 1; axi_awvalid = 0; end
            if (axi_wvalid && axi_wready) begin d_done = 1; axi_wvalid = 0; end
            if (a_done && d_done) begin
              phase = 1; axi_bvalid = 1; axi_bresp = 2'($urandom_range(3, 0));
            end
          end else if (axi_bvalid && axi_bready) begin
            axi_bvalid = 0; phase = 2;
          end
        end else begin
          if (phase == 0) begin
            if (axi_arvalid && axi_arready) begin
              axi_arvalid = 0; phase = 1; axi_rvalid = 1;
              axi_rdata = $urandom; axi_rresp = 2'($urandom_range(3, 0));
            end
          end else if (axi_rvalid && axi_rready) begin
            axi_rvalid = 0; phase = 2;
          end
        end
      end
      if (guard >= 100) begin
        miscompares++;
        $display("FAIL legal_txn_budget: transaction %0d did not complete in 100 cycles", n);
      end
    end
    set_idle();
    tick();
    vectors++;
    if (err_sticky !== 11'd0 || err_count !== 16'd0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL legal_summary: got sticky=%h cnt=%0d irq=%b, want 0/0/0",
               err_sticky, err_count, irq);
    end
  endtask

  task automatic test_addr_unstable();
    reset_dut();
    axi_awvalid = 1; axi_awaddr = 32'h1000; axi_awready = 0;
    tick();
    axi_awaddr = 32'h1004;
    tick();
    vectors++;
    if (err_pulse !== 11'h002 || first_err_id !== 4'd1 || err_count !== 16'd1 ||
        first_err_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL aw_unstable: got pulse=%h id=%0d cnt=%0d fv=%b, want 002/1/1/1",
               err_pulse, first_err_id, err_count, first_err_valid);
    end
    axi_awready = 1;
    tick();
    vectors++;
    if (err_pulse !== 11'd0) begin
      miscompares++;
      $display("FAIL aw_accept: got pulse=%h, want 000", err_pulse);
    end
    set_idle();
    tick();
  endtask

  task automatic test_b_unexpected();
    reset_dut();
    axi_bvalid = 1; axi_bready = 1;
    tick();
    vectors++;
    if (err_pulse !== 11'h040) begin
      miscompares++;
      $display("FAIL b_unexpected: got pulse=%h, want 040", err_pulse);
    end
    set_idle();
    reset_dut();
    axi_awvalid = 1; axi_awready = 1; axi_wvalid = 1; axi_wready = 1;
    axi_bvalid = 1; axi_bready = 1;
    tick();
    vectors++;
    if (err_pulse !== 11'd0) begin
      miscompares++;
      $display("FAIL b_same_cycle: got pulse=%h, want 000", err_pulse);
    end
    set_idle();
    tick();
    vectors++;
    if (err_sticky !== 11'd0 || err_pulse !== 11'd0) begin
      miscompares++;
      $display("FAIL b_same_cycle_after: got sticky=%h pulse=%h, want 000/000",
               err_sticky, err_pulse);
    end
  endtask

  task automatic test_timeout();
    logic [10:0] want;
    reset_dut();
    axi_arvalid = 1; axi_araddr = 32'hA5A5_0000; axi_arready = 0;
    for (int k = 1; k <= TMO + 3; k++) begin
      tick();
      want = (k == TMO) ? 11'h200 : 11'h000;
      vectors++;
      if (err_pulse !== want) begin
        miscompares++;
        $display("FAIL timeout_cycle%0d: got pulse=%h, want %h", k, err_pulse, want);
      end
    end
    vectors++;
    if (err_count !== 16'd1 || first_err_id !== 4'd9) begin
      miscompares++;
      $display("FAIL timeout_count: got cnt=%0d id=%0d, want 1/9", err_count, first_err_id);
    end
    axi_arready = 1;
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_ovf();
    logic [10:0] want;
    reset_dut();
    err_mask = 11'h400;
    axi_arvalid = 1; axi_arready = 1;
    for (int k = 1; k <= 5; k++) begin
      axi_araddr = $urandom;
      tick();
      want = (k == 5) ? 11'h400 : 11'h000;
      vectors++;
      if (err_pulse !== want || irq !== (k == 5)) begin
        miscompares++;
        $display("FAIL ovf_ar%0d: got pulse=%h irq=%b, want %h/%b", k, err_pulse, irq, want, k == 5);
      end
    end
    axi_arvalid = 0; axi_arready = 0;
    tick();
    vectors++;
    if (err_pulse !== 11'd0 || irq !== 1'b1 || err_sticky !== 11'h400) begin
      miscompares++;
      $display("FAIL ovf_hold: got pulse=%h irq=%b sticky=%h, want 000/1/400",
               err_pulse, irq, err_sticky);
    end
    clr = 1;
    tick();
    clr = 0;
    vectors++;
    if ({err_pulse, err_sticky, err_count, first_err_id, first_err_valid, irq} !== 44'd0) begin
      miscompares++;
      $display("FAIL ovf_clr: got pulse=%h sticky=%h cnt=%0d id=%0d fv=%b irq=%b, want all 0",
               err_pulse, err_sticky, err_count, first_err_id, first_err_valid, irq);
    end
  endtask

  task automatic test_clr_collision();
    reset_dut();
    axi_bvalid = 1; axi_bready = 1;
    tick();
    axi_bvalid = 0; axi_bready = 0;
    tick();
    clr = 1; axi_rvalid = 1; axi_rready = 1;
    tick();
    clr = 0; axi_rvalid = 0; axi_rready = 0;
    vectors++;
    if (err_sticky !== 11'h080 || err_count !== 16'd1 || first_err_id !== 4'd7 ||
        first_err_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_collision: got sticky=%h cnt=%0d id=%0d fv=%b, want 080/1/7/1",
               err_sticky, err_count, first_err_id, first_err_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    err_mask = '1;
    axi_arvalid = 1; axi_arready = 1; axi_araddr = 32'h40;
    tick();
    axi_arvalid = 0; axi_arready = 0;
    axi_awvalid = 1; axi_awaddr = 32'h2000; axi_awready = 0;
    tick();
    axi_awaddr = 32'h2004;
    tick();
    areset = 1;
    tick();
    vectors++;
    if ({err_pulse, err_sticky, err_count, first_err_id, first_err_valid, irq} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got pulse=%h sticky=%h cnt=%0d id=%0d fv=%b irq=%b, want all 0",
               err_pulse, err_sticky, err_count, first_err_id, first_err_valid, irq);
    end
    areset = 0; axi_awready = 1;
    tick();
    vectors++;
    if (err_pulse !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_mid_first: got pulse=%h, want 000", err_pulse);
    end
    axi_awvalid = 0; axi_awready = 0; axi_rvalid = 1; axi_rready = 1;
    tick();
    vectors++;
    if (err_pulse !== 11'h080) begin
      miscompares++;
      $display("FAIL reset_mid_stale_r: got pulse=%h, want 080", err_pulse);
    end
    set_idle();
    tick();
  endtask

  task automatic test_random_model();
    reset_dut();
    err_mask = 11'($urandom);
    for (int n = 0; n < 600; n++) begin
      areset      = ($urandom_range(99, 0) == 0);
      clr         = ($urandom_range(15, 0) == 0);
      axi_awvalid = 1'($urandom_range(1, 0)); axi_awready = 1'($urandom_range(1, 0));
      axi_wvalid  = 1'($urandom_range(1, 0)); axi_wready  = 1'($urandom_range(1, 0));
      axi_arvalid = 1'($urandom_range(1, 0)); axi_arready = 1'($urandom_range(1, 0));
      axi_bvalid  = ($urandom_range(3, 0) == 0); axi_bready = 1'($urandom_range(1, 0));
      axi_rvalid  = ($urandom_range(3, 0) == 0); axi_rready = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) axi_awaddr = $urandom;
      if ($urandom_range(3, 0) == 0) axi_wdata  = $urandom;
      if ($urandom_range(3, 0) == 0) axi_araddr = $urandom;
      if ($urandom_range(3, 0) == 0) axi_bresp  = 2'($urandom);
      if ($urandom_range(3, 0) == 0) axi_rdata  = $urandom;
      if ($urandom_range(7, 0) == 0) axi_rresp  = 2'($urandom);
      tick();
      vectors++;
      if ({err_pulse, err_sticky, err_count, first_err_id, first_err_valid, irq} !==
          {exp_pulse, exp_sticky, exp_count, exp_id, exp_fv, exp_irq}) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got pulse=%h sticky=%h cnt=%0d id=%0d fv=%b irq=%b, want %h %h %0d %0d %b %b",
                 n, err_pulse, err_sticky, err_count, first_err_id, first_err_valid, irq,
                 exp_pulse, exp_sticky, exp_count, exp_id, exp_fv, exp_irq);
      end
    end
    areset = 0;
    set_idle();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_legal_traffic();
    test_addr_unstable();
    test_b_unexpected();
    test_timeout();
    test_ovf();
    test_clr_collision();
    test_reset_mid();
    test_random_model();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
